note_key_tx: RTL

//  Reverse path of the keyboard LED decoder: takes a 12-bit one-hot note mask
//  (bit0=C .. bit11=B) and encodes it back to the ASCII key code of that note.

---
 rtl/note_key_tx_pkg.sv | 44 ++++
 rtl/uart_tx_8n1.sv | 89 ++++++++
 rtl/note_key_tx.sv | 45 ++++
 3 files changed

// File: rtl/note_key_tx_pkg.sv
// Shared keyboard keymap: note index <-> ASCII key code, plus the release/invalid codes.
// The LED decoder imports this same package so both directions of the mapping stay in step.
package note_key_tx_pkg;

    localparam logic [7:0] KEY_C       = 8'h7A; // z
    localparam logic [7:0] KEY_CS      = 8'h73; // s
    localparam logic [7:0] KEY_D       = 8'h78; // x
    localparam logic [7:0] KEY_DS      = 8'h64; // d
    localparam logic [7:0] KEY_E       = 8'h63; // c
    localparam logic [7:0] KEY_F       = 8'h76; // v
    localparam logic [7:0] KEY_FS      = 8'h67; // g
    localparam logic [7:0] KEY_G       = 8'h62; // b
    localparam logic [7:0] KEY_GS      = 8'h68; // h
    localparam logic [7:0] KEY_A       = 8'h6E; // n
    localparam logic [7:0] KEY_AS      = 8'h6A; // j
    localparam logic [7:0] KEY_B       = 8'h6D; // m
    localparam logic [7:0] KEY_RELEASE = 8'h20;
    localparam logic [7:0] KEY_INVALID = 8'h3F;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

    // Anything that is neither empty nor a single note maps to '?'.
    function automatic logic [7:0] encodeNote(input logic [11:0] note);
        logic [7:0] code;
        case (note)
            12'h000: code = KEY_RELEASE;
            12'h001: code = KEY_C;
            12'h002: code = KEY_CS;
            12'h004: code = KEY_D;
            12'h008: code = KEY_DS;
            12'h010: code = KEY_E;
            12'h020: code = KEY_F;
            12'h040: code = KEY_FS;
            12'h080: code = KEY_G;
            12'h100: code = KEY_GS;
            12'h200: code = KEY_A;
            12'h400: code = KEY_AS;
            12'h800: code = KEY_B;
            default: code = KEY_INVALID;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// UART 8N1 serialiser: a start strobe in IDLE launches one frame of the byte on data.
// data must stay stable for the whole frame; the caller owns the byte latch.
module uart_tx_8n1
    import note_key_tx_pkg::*;
#(
    parameter int unsigned ClksPerBit = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned CntW = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);

    uart_state_e     state;
    logic [CntW-1:0] bitCnt;
    logic [2:0]      bitIdx;
    logic [2:0]      nextIdx;

    assign nextIdx = bitIdx + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            tx     <= 1'b1;
            busy   <= 1'b0;
            bitCnt <= '0;
            bitIdx <= '0;
        end else begin
            case (state)
                StIdle: begin
                    tx     <= 1'b1;
                    bitCnt <= '0;
                    bitIdx <= '0;
                    if (start) begin
                        state <= StStart;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                StStart: begin
                    if (bitCnt == CntLast) begin
                        bitCnt <= '0;
                        bitIdx <= '0;
                        state  <= StData;
                        tx     <= data[0];
                    end else begin
                        bitCnt <= bitCnt + 1'b1;
                    end
                end
                StData: begin
                    if (bitCnt == CntLast) begin
                        bitCnt <= '0;
                        // Index wraps 7 -> 0 as the frame moves into the stop bit.
                        bitIdx <= nextIdx;
                        if (bitIdx == 3'd7) begin
                            state <= StStop;
                            tx    <= 1'b1;
                        end else begin
                            tx <= data[nextIdx];
                        end
                    end else begin
                        bitCnt <= bitCnt + 1'b1;
                    end
                end
                StStop: begin
                    tx <= 1'b1;
                    if (bitCnt == CntLast) begin
                        bitCnt <= '0;
                        state  <= StIdle;
                        busy   <= 1'b0;
                    end else begin
                        bitCnt <= bitCnt + 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/note_key_tx.sv
// Encodes a one-hot note mask to its ASCII key and sends it as one UART 8N1 frame.
// Accepts a note only while idle; no queueing.
module note_key_tx
    import note_key_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] inNote,
    input  logic        inValid,
    output logic        outReady,
    output logic        outTx,
    output logic        outBusy
);

    logic       busy;
    logic       accept;
    logic [7:0] byteQ;

    assign accept   = inValid && !busy;
    assign outReady = !busy;
    assign outBusy  = busy;

    // Byte is frozen at accept so mid-frame note changes cannot leak into the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            byteQ <= '0;
        end else if (accept) begin
            byteQ <= encodeNote(inNote);
        end
    end

    uart_tx_8n1 #(
        .ClksPerBit(CLKS_PER_BIT)
    ) uTx (
        .clk  (clk),
        .rst  (rst),
        .start(accept),
        .data (byteQ),
        .tx   (outTx),
        .busy (busy)
    );

endmodule
